// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES block types and IP / IP^-1 bit tables (index 0 = DES bit 1).
package des_pkg;

    typedef logic [63:0] des_block_t;
    typedef logic [31:0] des_half_t;

    // Index = output bit, value = source bit.
    localparam logic [5:0] FP_TABLE [64] = '{
        6'd39, 6'd7, 6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31,
        6'd38, 6'd6, 6'd46, 6'd14, 6'd54, 6'd22, 6'd62, 6'd30,
        6'd37, 6'd5, 6'd45, 6'd13, 6'd53, 6'd21, 6'd61, 6'd29,
        6'd36, 6'd4, 6'd44, 6'd12, 6'd52, 6'd20, 6'd60, 6'd28,
        6'd35, 6'd3, 6'd43, 6'd11, 6'd51, 6'd19, 6'd59, 6'd27,
        6'd34, 6'd2, 6'd42, 6'd10, 6'd50, 6'd18, 6'd58, 6'd26,
        6'd33, 6'd1, 6'd41, 6'd9,  6'd49, 6'd17, 6'd57, 6'd25,
        6'd32, 6'd0, 6'd40, 6'd8,  6'd48, 6'd16, 6'd56, 6'd24
    };

    localparam logic [5:0] IP_TABLE [64] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,
        6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,  6'd0,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6
    };

    function automatic des_block_t ip_permute(input des_block_t blk);
        des_block_t res;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            res[i] = blk[IP_TABLE[i]];
        end
        return res;
    endfunction

endpackage

// File: rtl/des_fp_perm.sv
// rtl/des_fp_perm.sv - combinational DES final permutation (IP^-1).
module des_fp_perm
    import des_pkg::*;
(
    input  des_block_t pre,
    output des_block_t blk
);

    for (genvar i = 0; i < 64; i++) begin : g_bit
        assign blk[i] = pre[FP_TABLE[i]];
    end

endmodule

// File: rtl/des_final_permutation_stage.sv
// rtl/des_final_permutation_stage.sv - IP^-1 output stage with DEPTH-entry buffer; DES_FP_ROUNDTRIP_CHECK_EN enables the IP round-trip checker.
module des_final_permutation_stage
    import des_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        l_half,
    input  logic [31:0]        r_half,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_block,
    output logic [COUNT_W-1:0] blk_count,
    output logic               check_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] OCC_FULL = (PW + 1)'(DEPTH);

    des_block_t pre;
    des_block_t perm;
    des_block_t mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_next;
    logic [PW:0]   occ;
    logic [PW:0]   occ_pop;
    logic [PW:0]   occ_next;
    logic          push;
    logic          pop;

    // Preoutput is R16||L16; with bit 1 at index 0, R16 lands in the low half.
    assign pre = {l_half, r_half};

    des_fp_perm u_fp_perm (
        .pre (pre),
        .blk (perm)
    );

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head_next = head + PW'(pop);
    assign occ_pop   = occ - {{PW{1'b0}}, pop};
    assign occ_next  = occ_pop + {{PW{1'b0}}, push};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_block <= '0;
            blk_count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= perm;
                tail      <= tail + PW'(1);
            end
            head      <= head_next;
            occ       <= occ_next;
            in_ready  <= (occ_next < OCC_FULL);
            out_valid <= (occ_next != '0);
            // Reload the output register only when the head entry changes; it holds otherwise.
            if ((pop || occ == '0) && occ_next != '0) begin
                out_block <= (occ_pop == '0) ? perm : mem[head_next];
            end
            if (pop) begin
                blk_count <= blk_count + COUNT_W'(1);
            end
        end
    end

`ifdef DES_FP_ROUNDTRIP_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            check_err <= 1'b0;
        end else if (push && ip_permute(perm) != pre) begin
            check_err <= 1'b1;
        end
    end
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_final_permutation_stage.sv
// tb/tb_des_final_permutation_stage.sv - scoreboard bench for des_final_permutation_stage.
module tb_des_final_permutation_stage;

    localparam int DEPTH   = 2;
    localparam int COUNT_W = 16;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        l_half;
    logic [31:0]        r_half;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_block;
    logic [COUNT_W-1:0] blk_count;
    logic               check_err;

    des_final_permutation_stage #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .l_half    (l_half),
        .r_half    (r_half),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .blk_count (blk_count),
        .check_err (check_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard DES initial permutation, 1-based as published.
    int ip_std [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    logic [63:0]        sb [$];
    int                 n_cmp;
    int                 n_err;
    int                 n_acc;
    logic [COUNT_W-1:0] exp_count;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fp_model(input logic [63:0] pre);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            res[ip_std[i] - 1] = pre[i];
        end
        return res;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] res;
        for (int i = 0; i < 32; i++) res[i] = v[31 - i];
        return res;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] res;
        for (int i = 0; i < 64; i++) res[i] = v[63 - i];
        return res;
    endfunction

    task automatic cycle(input logic iv, input logic [31:0] l, input logic [31:0] r, input logic ordy);
        logic [63:0] exp;
        @(negedge clk);
        in_valid  = iv;
        l_half    = l;
        r_half    = r;
        out_ready = ordy;
        check_eq("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
        check_eq("blk_count", 64'(blk_count), 64'(exp_count));
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_output", out_block, 64'hx);
            end else begin
                exp = sb.pop_front();
                check_eq("out_block", out_block, exp);
                exp_count++;
            end
        end
        if (iv && in_ready) begin
            sb.push_back(fp_model({l, r}));
            n_acc++;
        end
        @(posedge clk);
    endtask

    logic [63:0]        pre;
    logic [63:0]        first_blk;
    logic [63:0]        rnd;
    logic [COUNT_W-1:0] c0;

    initial begin
        n_cmp = 0; n_err = 0; n_acc = 0; exp_count = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; l_half = '0; r_half = '0;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_block", out_block, 64'd0);
        check_eq("rst_blk_count", 64'(blk_count), 64'd0);
        check_eq("rst_check_err", 64'(check_err), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        // Known answer: L16=43423234, R16=0A4CD995 -> 85E813540F0AB405.
        cycle(1'b1, rev32(32'h43423234), rev32(32'h0A4CD995), 1'b0);
        #1;
        check_eq("kat_valid", 64'(out_valid), 64'd1);
        check_eq("kat_block", out_block, rev64(64'h85E813540F0AB405));
        cycle(1'b0, '0, '0, 1'b1);

        // Single-bit walk over all preoutput positions.
        for (int p = 0; p < 64; p++) begin
            pre = 64'd1 << p;
            cycle(1'b1, pre[63:32], pre[31:0], 1'b1);
        end
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);

        // Backpressure: 3 offered, only 2 fit.
        n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            rnd = {$urandom, $urandom};
            cycle(1'b1, rnd[63:32], rnd[31:0], 1'b0);
        end
        first_blk = sb[0];
        #1;
        check_eq("bp_accepted", 64'(n_acc), 64'd2);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_head_stable", out_block, first_blk);
        cycle(1'b0, '0, '0, 1'b0);
        #1;
        check_eq("bp_head_stable2", out_block, first_blk);
        // Drain in push order.
        repeat (3) cycle(1'b0, '0, '0, 1'b1);

        // Streaming: 100 blocks back to back.
        c0 = exp_count;
        for (int k = 0; k < 100; k++) begin
            rnd = {$urandom, $urandom};
            cycle(1'b1, rnd[63:32], rnd[31:0], 1'b1);
        end
        cycle(1'b0, '0, '0, 1'b1);
        #1;
        check_eq("stream_count", 64'(blk_count), 64'(c0 + COUNT_W'(100)));

        // Reset mid-operation with two blocks buffered.
        for (int k = 0; k < 2; k++) begin
            rnd = {$urandom, $urandom};
            cycle(1'b1, rnd[63:32], rnd[31:0], 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_blk_count", 64'(blk_count), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("mid_rst_out_block", out_block, 64'd0);
        sb.delete();
        exp_count = '0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            rnd = {$urandom, $urandom};
            cycle(1'b1, rnd[63:32], rnd[31:0], k[0]);
        end
        repeat (3) cycle(1'b0, '0, '0, 1'b1);

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        check_eq("check_err_final", 64'(check_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
